// File: rtl/conv_channel_accumulator_if.sv
// Handshake bundle between the stage-3 adder and the channel accumulator.
// The upstream side is the master and the accumulator is the slave.
interface conv_channel_accumulator_if #(
  parameter int IN_W   = 19,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic signed [IN_W-1:0]   in_data;
  logic signed [BIAS_W-1:0] bias;
  logic                     relu_en;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     busy;

  modport master (
    output in_valid, in_data, bias, relu_en,
    input  out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  in_valid, in_data, bias, relu_en,
    output out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/conv_channel_accumulator.sv
// Sums NUM_CH channel partial sums plus bias, then rounds, scales, optionally
// rectifies and saturates into one OUT_W activation per group.
module conv_channel_accumulator #(
  parameter int IN_W   = 19,
  parameter int NUM_CH = 3,
  parameter int BIAS_W = 16,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 16
) (
  input logic                      clk,
  input logic                      reset,
  conv_channel_accumulator_if.slave bus
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One guard bit so adding the rounding constant can never wrap.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF =
    (SHIFT > 0) ? (RW'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OMIN = -OMAX - RW'(1);

  function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] x);
    logic signed [RW-1:0] xe;
    xe = {x[ACC_W-1], x};
    return (xe + HALF) >>> SHIFT;
  endfunction

  // Returns {sat, data}; ReLU takes priority and never flags saturation.
  function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] r, input logic relu);
    if (relu && (r < 0))
      return {1'b0, {OUT_W{1'b0}}};
    else if (r > OMAX)
      return {1'b1, OMAX[OUT_W-1:0]};
    else if (r < OMIN)
      return {1'b1, OMIN[OUT_W-1:0]};
    else
      return {1'b0, r[OUT_W-1:0]};
  endfunction

  logic        [CW-1:0]    ch_cnt_p0;
  logic signed [ACC_W-1:0] acc_p0;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] final_p1;
  logic                    relu_p1;
  logic                    pend_p1;
  logic                    out_valid_p2;
  logic signed [OUT_W-1:0] out_data_p2;
  logic                    out_sat_p2;
  logic                    first_beat;
  logic                    last_beat;
  logic        [OUT_W:0]   sat_res;
  logic signed [ACC_W-1:0] data_ext;
  logic signed [ACC_W-1:0] bias_ext;

  always_comb begin
    first_beat = (ch_cnt_p0 == '0);
    last_beat  = (ch_cnt_p0 == CW'(NUM_CH - 1));
    data_ext   = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    bias_ext   = {{(ACC_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias};
    acc_next   = first_beat ? (bias_ext + data_ext) : (acc_p0 + data_ext);
    sat_res    = saturate(round_shift(final_p1), relu_p1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_cnt_p0    <= '0;
      acc_p0       <= '0;
      final_p1     <= '0;
      relu_p1      <= 1'b0;
      pend_p1      <= 1'b0;
      out_valid_p2 <= 1'b0;
      out_data_p2  <= '0;
      out_sat_p2   <= 1'b0;
    end else begin
      // p2: post stage consumes the pending result; data holds between pulses
      out_valid_p2 <= pend_p1;
      if (pend_p1) begin
        out_data_p2 <= sat_res[OUT_W-1:0];
        out_sat_p2  <= sat_res[OUT_W];
        pend_p1     <= 1'b0;
      end else begin
        out_sat_p2  <= 1'b0;
      end
      // p0/p1: accumulate; a last beat re-arms pend in the same cycle it drains
      if (bus.in_valid) begin
        if (last_beat) begin
          final_p1  <= acc_next;
          relu_p1   <= bus.relu_en;
          pend_p1   <= 1'b1;
          acc_p0    <= '0;
          ch_cnt_p0 <= '0;
        end else begin
          acc_p0    <= acc_next;
          ch_cnt_p0 <= ch_cnt_p0 + CW'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_p2;
  assign bus.out_data  = out_data_p2;
  assign bus.out_sat   = out_sat_p2;
  assign bus.busy      = (ch_cnt_p0 != '0) | pend_p1;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Two accumulators (SHIFT=6 and SHIFT=2) fed the same stream, checked every
// cycle against a group-level arithmetic model plus hand-computed results.
module tb_conv_channel_accumulator;
  localparam int IN_W   = 19;
  localparam int NUM_CH = 3;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                     iv;
  logic signed [IN_W-1:0]   id;
  logic signed [BIAS_W-1:0] ib;
  logic                     ir;

  conv_channel_accumulator_if #(.IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) ifa ();
  conv_channel_accumulator_if #(.IN_W(IN_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) ifb ();

  assign ifa.in_valid = iv;
  assign ifa.in_data  = id;
  assign ifa.bias     = ib;
  assign ifa.relu_en  = ir;
  assign ifb.in_valid = iv;
  assign ifb.in_data  = id;
  assign ifb.bias     = ib;
  assign ifb.relu_en  = ir;

  conv_channel_accumulator #(.IN_W(IN_W), .NUM_CH(NUM_CH), .BIAS_W(BIAS_W),
                             .ACC_W(ACC_W), .SHIFT(6), .OUT_W(OUT_W))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));

  conv_channel_accumulator #(.IN_W(IN_W), .NUM_CH(NUM_CH), .BIAS_W(BIAS_W),
                             .ACC_W(ACC_W), .SHIFT(2), .OUT_W(OUT_W))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Group-level reference: rounding shift, ReLU, clamp.
  function automatic void model_out(input longint sum, input int sh, input bit relu,
                                    output int d, output bit s);
    longint r;
    r = (sum + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0))) >>> sh;
    s = 1'b0;
    if (relu && r < 0) d = 0;
    else if (r > 32767) begin d = 32767; s = 1'b1; end
    else if (r < -32768) begin d = -32768; s = 1'b1; end
    else d = int'(r);
  endfunction

  typedef struct {
    int due;
    int d0;
    int d1;
    bit s0;
    bit s1;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     nbeats = 0;
  longint gsum = 0;
  bit     last_at = 1'b0;
  bit     rst_at = 1'b0;
  bit     armed = 1'b0;
  int     hold0 = 0;
  int     hold1 = 0;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    last_at = 1'b0;
    rst_at  = 1'b0;
    if (reset) begin
      armed  = 1'b1;
      rst_at = 1'b1;
      nbeats = 0;
      gsum   = 0;
      q.delete();
    end else if (iv) begin
      if (nbeats == 0) gsum = longint'(ib);
      gsum += longint'(id);
      nbeats++;
      if (nbeats == NUM_CH) begin
        e.due = cyc + 1;
        model_out(gsum, 6, ir, e.d0, e.s0);
        model_out(gsum, 2, ir, e.d1, e.s1);
        q.push_back(e);
        nbeats  = 0;
        last_at = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   expv;
    if (armed) begin
      if (rst_at) begin hold0 = 0; hold1 = 0; end
      expv = (q.size() > 0) && (q[0].due == cyc);
      e.s0 = 1'b0;
      e.s1 = 1'b0;
      if (expv) begin
        e = q.pop_front();
        hold0 = e.d0;
        hold1 = e.d1;
      end
      chk("valid_a", longint'(ifa.out_valid), longint'(expv));
      chk("valid_b", longint'(ifb.out_valid), longint'(expv));
      chk("data_a",  longint'(ifa.out_data), longint'(hold0));
      chk("data_b",  longint'(ifb.out_data), longint'(hold1));
      chk("sat_a",   longint'(ifa.out_sat), longint'(expv & e.s0));
      chk("sat_b",   longint'(ifb.out_sat), longint'(expv & e.s1));
      chk("busy_a",  longint'(ifa.busy), longint'((nbeats != 0) || last_at));
      chk("busy_b",  longint'(ifb.busy), longint'((nbeats != 0) || last_at));
    end
  end

  task automatic drive(input bit r, input bit v, input int d, input int b, input bit relu);
    @(negedge clk);
    reset = r;
    iv    = v;
    id    = IN_W'(d);
    ib    = BIAS_W'(b);
    ir    = relu;
  endtask

  // Three back-to-back beats, then check the pulse two edges after the last beat.
  task automatic run_group(input int d0, input int d1, input int d2, input int b, input bit relu,
                           input int ea, input bit sa, input int eb, input bit sb);
    drive(0, 1, d0, b, relu);
    drive(0, 1, d1, b, relu);
    drive(0, 1, d2, b, relu);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_valid_a", longint'(ifa.out_valid), 1);
    chk("lit_valid_b", longint'(ifb.out_valid), 1);
    chk("lit_data_a",  longint'(ifa.out_data), longint'(ea));
    chk("lit_sat_a",   longint'(ifa.out_sat), longint'(sa));
    chk("lit_data_b",  longint'(ifb.out_data), longint'(eb));
    chk("lit_sat_b",   longint'(ifb.out_sat), longint'(sb));
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
  endfunction

  function automatic int rnd_bias();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    reset = 1'b1;
    iv = 1'b0;
    id = '0;
    ib = '0;
    ir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(ifa.out_valid), 0);
    chk("rst_data",  longint'(ifa.out_data), 0);
    chk("rst_sat",   longint'(ifa.out_sat), 0);
    chk("rst_busy",  longint'(ifa.busy), 0);
    drive(0, 0, 0, 0, 0);

    run_group(100, 200, 300, 40, 0, 10, 0, 160, 0);
    run_group(-1000, -1000, -1000, 0, 0, -47, 0, -750, 0);
    run_group(-1000, -1000, -1000, 0, 1, 0, 0, 0, 0);
    run_group(262143, 262143, 262143, 32767, 0, 12800, 0, 32767, 1);
    run_group(-262144, -262144, -262144, -32768, 0, -12800, 0, -32768, 1);

    // Two groups back-to-back, bias/relu varying per beat.
    for (int i = 0; i < 2 * NUM_CH; i++)
      drive(0, 1, rnd_data(), rnd_bias(), 1'($urandom_range(0, 1)));
    // One group with random gaps.
    for (int n = 0; n < NUM_CH; ) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      drive(0, v, rnd_data(), rnd_bias(), 1'($urandom_range(0, 1)));
      if (v) n++;
    end
    repeat (4) drive(0, 0, 0, 0, 0);

    // Partial group discarded by reset (reset wins over a coincident beat).
    drive(0, 1, 5000, 100, 0);
    drive(0, 1, 7000, 100, 0);
    drive(1, 1, 9000, 100, 0);
    run_group(64, 64, 64, 0, 0, 3, 0, 48, 0);

    // Pending result dropped by reset on the cycle after the last beat.
    drive(0, 1, 1000, 0, 0);
    drive(0, 1, 1000, 0, 0);
    drive(0, 1, 1000, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0)
        drive(1, 1'($urandom_range(0, 1)), rnd_data(), rnd_bias(), 1'($urandom_range(0, 1)));
      else
        drive(0, ($urandom_range(0, 3) != 0), rnd_data(), rnd_bias(), 1'($urandom_range(0, 1)));
    end
    repeat (5) drive(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
